prog_loader: RTL

Host-side sequencer that sits directly upstream of the tiny processor's serial port. It accepts parallel commands (load instruction word, load data word, run program) and converts each into the processor's pin protocol: select encoding on the two select pins, a 12-bit LSB-first frame on MOSI, and the run-enable/done handshake. It also reports run length and timeout to the host.

---
 rtl/prog_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: host-side sequencer for the tiny processor's serial port.
// Turns parallel host commands into select/MOSI frames and a gated
// run/done handshake, and reports run length and timeout to the host.
//
// Host handshake: a command is consumed on a rising clk edge where
// cmd_valid and cmd_ready are both high. cmd_ready is high only in IDLE.
// A command presented while busy stays pending and is not consumed until
// IDLE is reached.
module prog_loader #(
  parameter int GAP_CYCLES  = 2,
  parameter int RUN_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       proc_done_in,
  output logic [1:0] sel_out,
  output logic       mosi_out,
  output logic       busy_out,
  output logic       run_done_out,
  output logic       run_timeout_out,
  output logic [7:0] run_cycles_out,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] RUN_LAST = 8'(RUN_TIMEOUT);

  state_t      state;
  logic [11:0] frame;
  logic [3:0]  bit_cnt;
  logic [7:0]  gap_cnt;
  logic [7:0]  run_cnt;   // index of the current RUN cycle, 1-based
  logic        armed;
  logic [1:0]  sel_reg;
  logic        run_complete;
  logic        run_abort;
  logic        run_end;

  // Completion wins over abort when both land in the same cycle.
  always_comb begin
    run_complete = (state == S_RUN) && armed && proc_done_in;
    run_abort    = (state == S_RUN) && (run_cnt == RUN_LAST) && !run_complete;
    run_end      = run_complete || run_abort;
  end

  // Select is registered except that a finishing run drops it immediately,
  // so the processor never sees run-select together with done high.
  assign sel_out      = run_end ? 2'b00 : sel_reg;
  assign run_done_out = run_end;
  assign cmd_ready    = (state == S_IDLE);
  assign state_dbg    = state;

  // Sequencer: command decode, frame shifting, gap timing and run supervision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      frame           <= '0;
      bit_cnt         <= '0;
      gap_cnt         <= '0;
      run_cnt         <= '0;
      armed           <= 1'b0;
      sel_reg         <= 2'b00;
      mosi_out        <= 1'b0;
      busy_out        <= 1'b0;
      run_timeout_out <= 1'b0;
      run_cycles_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_kind)
              2'b00, 2'b01: begin
                frame    <= {cmd_data, cmd_addr};
                bit_cnt  <= '0;
                mosi_out <= cmd_addr[0];
                sel_reg  <= (cmd_kind == 2'b00) ? 2'b01 : 2'b10;
                busy_out <= 1'b1;
                state    <= S_SHIFT;
              end
              2'b10: begin
                armed           <= 1'b0;
                run_cycles_out  <= '0;
                run_timeout_out <= 1'b0;
                run_cnt         <= 8'd1;
                sel_reg         <= 2'b11;
                busy_out        <= 1'b1;
                state           <= S_RUN;
              end
              default: ;  // no-op: consumed, nothing happens on the pins
            endcase
          end
        end
        S_SHIFT: begin
          if (bit_cnt == 4'd11) begin
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            sel_reg  <= 2'b00;
            mosi_out <= 1'b0;
            state    <= S_GAP;
          end else begin
            bit_cnt  <= bit_cnt + 4'd1;
            mosi_out <= frame[bit_cnt + 4'd1];
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy_out <= 1'b0;
            state    <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (!proc_done_in) begin
            armed <= 1'b1;
            if (run_cycles_out != 8'hFF) run_cycles_out <= run_cycles_out + 8'd1;
          end
          if (run_end) begin
            sel_reg  <= 2'b00;
            busy_out <= 1'b0;
            state    <= S_IDLE;
            if (run_abort) run_timeout_out <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
